// File: rtl/pkt_receiver.sv
// Egress packet receiver: parses HDR/LEN/payload/PAR frames and checks them.
// Payload is staged in a commit/rollback FIFO so only good packets reach the consumer.
module pkt_receiver #(
    parameter int DATA_W     = 8,
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        port_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output logic [7:0]        pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0] LP_DEPTH = (AW+2)'(FIFO_DEPTH);
    localparam logic [AW+1:0] LP_MAX   = (AW+2)'(MAX_LEN);
    localparam logic [DATA_W-1:0] LP_MAXB = DATA_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_PAR,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [AW:0]       r_wr;
    logic [AW:0]       r_commit;
    logic [AW:0]       r_rd;
    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [8:0]        r_cnt;
    logic [DATA_W-1:0] r_xor;
    logic              r_addr_ok;
    logic              r_len_zero;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_last;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_code;
    logic [7:0]        r_count;

    logic [AW:0]       w_used;
    logic [AW+1:0]     w_free;
    logic              w_rdy;
    logic              w_xfer;
    logic              w_pop;
    logic              w_we;
    logic              w_valid;
    logic [DATA_W:0]   w_head;
    logic [1:0]        w_par_code;
    logic              w_len_big;

    assign w_used    = r_wr - r_rd;
    assign w_free    = LP_DEPTH - {1'b0, w_used};
    assign w_rdy     = (r_state == S_IDLE) ? (w_free >= LP_MAX) : 1'b1;
    assign in_ready  = w_rdy & ~reset;
    assign w_xfer    = in_valid & in_ready;
    assign w_valid   = (r_rd != r_commit);
    assign w_pop     = w_valid & out_ready;
    assign w_head    = r_mem[r_rd[AW-1:0]];
    assign w_we      = w_xfer & (r_state == S_PAYLOAD) & r_addr_ok;
    assign w_len_big = (in_data > LP_MAXB);

    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_head[DATA_W-1:0] : r_hold_data;
    assign out_last  = w_valid ? w_head[DATA_W] : r_hold_last;
    assign pkt_done  = r_done;
    assign pkt_err   = r_err;
    assign err_code  = r_code;
    assign pkt_count = r_count;

    // Address beats length, length beats parity
    always_comb begin
        w_par_code = 2'd0;
        if (!r_addr_ok)
            w_par_code = 2'd1;
        else if (r_len_zero)
            w_par_code = 2'd2;
        else if (r_xor != in_data)
            w_par_code = 2'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer)
                    w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) begin
                    if (in_data == '0)
                        w_next = S_PAR;
                    else if (w_len_big)
                        w_next = S_DROP;
                    else
                        w_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_xfer && r_cnt == 9'd1)
                    w_next = S_PAR;
            end
            S_PAR: begin
                if (w_xfer)
                    w_next = S_IDLE;
            end
            S_DROP: begin
                if (w_xfer && r_cnt == 9'd1)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr[AW-1:0]] <= {(r_cnt == 9'd1), in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr        <= '0;
            r_commit    <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_xor       <= '0;
            r_addr_ok   <= 1'b0;
            r_len_zero  <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_code      <= 2'd0;
            r_count     <= 8'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_valid) begin
                r_hold_data <= w_head[DATA_W-1:0];
                r_hold_last <= w_head[DATA_W];
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (w_xfer) begin
                unique case (r_state)
                    S_IDLE: begin
                        r_addr_ok <= (in_data[1:0] == port_addr) &&
                                     (in_data[DATA_W-1:2] == '0);
                        r_xor     <= in_data;
                    end
                    S_LEN: begin
                        r_xor      <= r_xor ^ in_data;
                        r_len_zero <= (in_data == '0);
                        // Drop covers the oversize payload plus its PAR byte
                        if (w_len_big)
                            r_cnt <= {1'b0, in_data} + 9'd1;
                        else
                            r_cnt <= {1'b0, in_data};
                    end
                    S_PAYLOAD: begin
                        r_xor <= r_xor ^ in_data;
                        r_cnt <= r_cnt - 9'd1;
                        if (r_addr_ok)
                            r_wr <= r_wr + 1'b1;
                    end
                    S_PAR: begin
                        r_done <= 1'b1;
                        r_err  <= (w_par_code != 2'd0);
                        r_code <= w_par_code;
                        if (w_par_code == 2'd0) begin
                            r_commit <= r_wr;
                            r_count  <= r_count + 8'd1;
                        end else begin
                            r_wr <= r_commit;
                        end
                    end
                    S_DROP: begin
                        r_cnt <= r_cnt - 9'd1;
                        if (r_cnt == 9'd1) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                            r_code <= 2'd2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_receiver.sv
// Directed bench for pkt_receiver: framing, error codes, rollback,
// backpressure and asynchronous reset.
module tb_pkt_receiver;

    logic       clk;
    logic       reset;
    logic [1:0] port_addr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [7:0] pkt_count;

    int errors = 0;
    int checks = 0;

    pkt_receiver #(
        .DATA_W(8),
        .MAX_LEN(16),
        .FIFO_DEPTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .port_addr(port_addr),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_ready(out_ready),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err),
        .err_code(err_code),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] len,
                              input logic [7:0] first, input logic [7:0] step,
                              input bit bad_par);
        logic [7:0] p;
        logic [7:0] b;
        p = hdr ^ len;
        b = first;
        send(hdr);
        send(len);
        for (int i = 0; i < int'(len); i++) begin
            send(b);
            p = p ^ b;
            b = b + step;
        end
        send(bad_par ? 8'h00 : p);
    endtask

    task automatic pop(input logic [7:0] d, input logic l);
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, d);
        chk("out_last", out_last, l);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        port_addr = 2'd2;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_err", pkt_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Good frame 02,03,AA,BB,CC,DC
        send_frame(8'h02, 8'd3, 8'hAA, 8'h11, 1'b0);
        chk("good_done", pkt_done, 1);
        chk("good_err", pkt_err, 0);
        chk("good_code", err_code, 0);
        chk("good_count", pkt_count, 1);
        pop(8'hAA, 1'b0);
        pop(8'hBB, 1'b0);
        pop(8'hCC, 1'b1);
        chk("good_empty", out_valid, 0);
        chk("hold_data", out_data, 8'hCC);
        chk("hold_last", out_last, 1);

        // Bad parity then rollback
        send_frame(8'h02, 8'd3, 8'hAA, 8'h11, 1'b1);
        chk("par_done", pkt_done, 1);
        chk("par_err", pkt_err, 1);
        chk("par_code", err_code, 3);
        chk("par_count", pkt_count, 1);
        chk("par_empty", out_valid, 0);
        @(negedge clk);
        chk("par_pulse", pkt_done, 0);
        chk("par_code_held", err_code, 3);
        send_frame(8'h02, 8'd3, 8'hAA, 8'h11, 1'b0);
        chk("rb_code", err_code, 0);
        chk("rb_count", pkt_count, 2);
        pop(8'hAA, 1'b0);
        pop(8'hBB, 1'b0);
        pop(8'hCC, 1'b1);
        chk("rb_empty", out_valid, 0);

        // Address mismatches
        send_frame(8'h01, 8'd2, 8'h11, 8'h11, 1'b0);
        chk("addr_err", pkt_err, 1);
        chk("addr_code", err_code, 1);
        chk("addr_empty", out_valid, 0);
        send_frame(8'h42, 8'd1, 8'h55, 8'h00, 1'b0);
        chk("hdr_hi_code", err_code, 1);
        chk("hdr_hi_count", pkt_count, 2);

        // Length errors
        send_frame(8'h02, 8'd0, 8'h00, 8'h00, 1'b0);
        chk("len0_done", pkt_done, 1);
        chk("len0_code", err_code, 2);
        send_frame(8'h02, 8'd20, 8'h01, 8'h01, 1'b0);
        chk("len20_done", pkt_done, 1);
        chk("len20_err", pkt_err, 1);
        chk("len20_code", err_code, 2);
        chk("len20_empty", out_valid, 0);
        send_frame(8'h02, 8'd2, 8'h5A, 8'h01, 1'b0);
        chk("after_drop_code", err_code, 0);
        chk("after_drop_count", pkt_count, 3);
        pop(8'h5A, 1'b0);
        pop(8'h5B, 1'b1);

        // Backpressure fills the FIFO
        send_frame(8'h02, 8'd16, 8'h10, 8'h01, 1'b0);
        send_frame(8'h02, 8'd16, 8'h40, 8'h01, 1'b0);
        chk("full_count", pkt_count, 5);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'h02;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++)
            pop(8'h10 + 8'(i), (i == 15));
        chk("drain_in_ready", in_ready, 1);
        chk("pending_valid", out_valid, 1);
        chk("pending_data", out_data, 8'h40);

        // Reset mid-payload with one packet pending
        send(8'h02);
        send(8'h04);
        send(8'h77);
        send(8'h88);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_count", pkt_count, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_err_code", err_code, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        send_frame(8'h02, 8'd2, 8'hE1, 8'h01, 1'b0);
        chk("fresh_done", pkt_done, 1);
        chk("fresh_code", err_code, 0);
        chk("fresh_count", pkt_count, 1);
        pop(8'hE1, 1'b0);
        pop(8'hE2, 1'b1);
        chk("fresh_empty", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_receiver.md
Name: pkt_receiver

Overview:
- Egress-side packet receiver. It is the receiving end of the byte-serial packet protocol that dut_top drives out of a switch port.
- Accepts framed bytes on a valid/ready input and checks address, length and parity.
- Buffers each packet in a commit/rollback FIFO. Only packets that pass every check are released to the downstream consumer on a valid/ready output with a last marker.

Parameters:
- DATA_W, 8, byte width of in/out data; the frame format requires 8.
- MAX_LEN, 16, maximum legal payload length in bytes.
- FIFO_DEPTH, 32, payload storage entries (DATA_W+1 bits each: data plus last flag). Power of two, >= MAX_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_addr  in  2  this port's address; held static in operation.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  receiver can accept in_data.
- out_valid  out  1  committed payload byte available.
- out_data  out  8  payload byte at FIFO head.
- out_last  out  1  out_data is the final byte of its packet.
- out_ready  in  1  consumer accepts out_data.
- pkt_done  out  1  one-cycle pulse: frame finished.
- pkt_err  out  1  one-cycle pulse with pkt_done: frame rejected.
- err_code  out  2  0 none, 1 address mismatch, 2 bad length, 3 parity; held until next pkt_done.
- pkt_count  out  8  good packets committed, wraps 255->0.

Behaviour:
- Frame format: HDR, LEN, L payload bytes, PAR.
  - HDR[1:0] is the destination and HDR[7:2] must be 0.
  - PAR = XOR of HDR, LEN and all payload bytes.
- Byte transfer occurs when in_valid & in_ready at a rising clk. Output transfer occurs when out_valid & out_ready.
- Reset (async, any time): FSM to IDLE; wr_ptr, commit_ptr and rd_ptr to 0; drop counter to 0. Outputs reset to: in_ready 0, out_valid 0, out_data 0, out_last 0, pkt_done 0, pkt_err 0, err_code 0, pkt_count 0. Any partial or uncommitted packet is lost; in_ready returns 1 the first cycle after reset deasserts.
- FSM states: IDLE, LEN, PAYLOAD, PAR, DROP.
  - IDLE: in_ready = (free >= MAX_LEN), where free = FIFO_DEPTH - (wr_ptr - rd_ptr). On HDR: latch address-match (HDR[1:0]==port_addr and HDR[7:2]==0), start the running XOR, go to LEN.
  - LEN: latch L.
    - L==0: go to PAR; error 2 at PAR.
    - L>MAX_LEN: load drop counter = L+1 (9-bit), go to DROP, error 2.
    - Otherwise go to PAYLOAD. On an address mismatch, payload is still consumed but not written, and error 1 is reported at PAR.
  - PAYLOAD: each byte is written at wr_ptr (only if the address matched); last flag set on the L-th byte; XOR is updated. After L bytes, go to PAR.
  - PAR: compare the XOR to the byte.
    - Error priority: 1 > 2 > 3.
    - If no error: commit_ptr <= wr_ptr and pkt_count increments.
    - If any error: wr_ptr <= commit_ptr (rollback).
    - Either way, go to IDLE.
  - DROP: bytes are accepted and discarded, and the counter decrements. On the final byte, go to IDLE with error 2.
- in_ready is held at 1 in LEN, PAYLOAD, PAR and DROP. Space was reserved at IDLE, so no stall occurs mid-frame.
- pkt_done and pkt_err are registered and pulse in the cycle after the PAR or final DROP byte is accepted. err_code updates in that same cycle.
- Output side is first-word-fall-through:
  - out_valid = (rd_ptr != commit_ptr); out_data/out_last are the entry at rd_ptr.
  - A committed packet is visible in the same cycle as its pkt_done pulse.
  - Uncommitted bytes are never visible.
  - When out_valid is 0, out_data and out_last are held at their last values.
- Simultaneous write and read in one cycle are both performed. free uses the current rd_ptr. Rollback never moves wr_ptr behind rd_ptr.
- Pointers are log2(FIFO_DEPTH)+1 bits for full/empty disambiguation; wrap-around is natural modulo.
- Inputs arriving during in_ready==0 are ignored (no transfer).

Test Plan:
- port_addr=2; frame 02,03,AA,BB,CC,PAR=0x02^0x03^0xAA^0xBB^0xCC=0xDC -> pkt_done=1, pkt_err=0, err_code=0, pkt_count=1. Out stream AA,BB,CC with out_last only on CC.
- Same frame with PAR=0x00 -> pkt_err=1, err_code=3, out_valid stays 0, pkt_count unchanged; next good frame drains correctly (rollback).
- HDR=01 with port_addr=2, LEN=2 -> 5 bytes consumed, err_code=1, nothing output. HDR=0x42 -> err_code=1.
- LEN=0 -> err_code=2 after 3 bytes. LEN=20 -> 21 further bytes dropped, err_code=2, then the next frame is received normally.
- out_ready=0; send two 16-byte good frames -> in_ready drops in IDLE (free=0 <16). Raising out_ready for 16 transfers -> in_ready=1 again.
- Assert reset mid-PAYLOAD with one committed packet pending -> out_valid=0, pkt_count=0, all outputs 0 immediately. A fresh frame is received correctly after release.
